// File: rtl/hyperbolic_cordic_pkg.sv
// Shared constants, tables and types for the 2.14 hyperbolic CORDIC blocks.
// Angle table entries are atanh(2^-s) scaled by 2^(FRAC_W+GUARD_W).
package hyperbolic_cordic_pkg;

    localparam int NUM_W           = 16;
    localparam int FRAC_W          = 14;
    localparam int GUARD_W         = 4;
    localparam int INT_W           = 4;
    localparam int ACC_W           = INT_W + FRAC_W + GUARD_W;
    localparam int RND_W           = ACC_W + 1 - GUARD_W;
    localparam int ITERATION_COUNT = 18;
    localparam int CNT_W           = 5;
    localparam int LN_A_MIN        = 2218;

    localparam int SHIFT [ITERATION_COUNT] = '{
        1, 2, 3, 4, 4, 5, 6, 7, 8,
        9, 10, 11, 12, 13, 13, 14, 15, 16
    };

    localparam int ATANH [ITERATION_COUNT] = '{
        143996, 66955, 32940, 16405, 16405,
        8195, 4096, 2048, 1024, 512, 256,
        128, 64, 32, 32, 16, 8, 4
    };

    typedef logic signed [ACC_W-1:0] acc_t;

    typedef struct packed {
        acc_t x;
        acc_t y;
        acc_t z;
    } vec_t;

    function automatic logic signed [NUM_W-1:0] sat16(
        input logic signed [RND_W-1:0] v
    );
        if (v[RND_W-1:NUM_W-1] == '0 || v[RND_W-1:NUM_W-1] == '1)
            return v[NUM_W-1:0];
        if (v[RND_W-1])
            return {1'b1, {(NUM_W-1){1'b0}}};
        return {1'b0, {(NUM_W-1){1'b1}}};
    endfunction

endpackage

// File: rtl/hyperbolic_ln_cordic_if.sv
// Operand/result handshake bundle for the ln CORDIC block.
// slave is the block side, master the producer/consumer side.
interface hyperbolic_ln_cordic_if;
    import hyperbolic_cordic_pkg::*;

    logic signed [NUM_W-1:0] a;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [NUM_W-1:0] w;
    logic                    out_err;
    logic                    out_sat;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output a, in_valid, out_ready,
        input  in_ready, w, out_err, out_sat, out_valid
    );

    modport slave (
        input  a, in_valid, out_ready,
        output in_ready, w, out_err, out_sat, out_valid
    );

endinterface

// File: rtl/hyperbolic_vec_step.sv
// One hyperbolic vectoring micro-rotation driving y towards zero.
// Both updates use the incoming x/y, never the freshly rotated ones.
module hyperbolic_vec_step
    import hyperbolic_cordic_pkg::*;
(
    input  vec_t             cur,
    input  logic [CNT_W-1:0] s,
    input  acc_t             t,
    output vec_t             nxt
);

    acc_t xs;
    acc_t ys;

    assign xs = $signed(cur.x) >>> s;
    assign ys = $signed(cur.y) >>> s;

    always_comb begin
        nxt = cur;
        if (cur.y[ACC_W-1]) begin
            nxt.x = cur.x + ys;
            nxt.y = cur.y + xs;
            nxt.z = cur.z - t;
        end else begin
            nxt.x = cur.x - ys;
            nxt.y = cur.y - xs;
            nxt.z = cur.z + t;
        end
    end

endmodule

// File: rtl/hyperbolic_ln_cordic.sv
// ln(a) = 2*atanh((a-1)/(a+1)) by iterative hyperbolic vectoring CORDIC.
// One operand in flight, fixed 19-cycle accept-to-result latency.
module hyperbolic_ln_cordic
    import hyperbolic_cordic_pkg::*;
(
    input logic                   clk,
    input logic                   rst,
    hyperbolic_ln_cordic_if.slave io
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ITER  = 2'd1;
    localparam logic [1:0] S_FINAL = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam acc_t ONE = acc_t'(1 << (FRAC_W + GUARD_W));
    localparam logic signed [ACC_W:0] RND_HALF =
        (ACC_W + 1)'(1 << (GUARD_W - 1));
    localparam logic [NUM_W-1:0] W_FLAG = {1'b1, {(NUM_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERATION_COUNT - 1);

    logic [1:0]              state;
    logic [CNT_W-1:0]        cnt;
    vec_t                    vec_q;
    vec_t                    vec_nxt;
    logic                    err_q;
    logic                    sat_q;
    logic signed [NUM_W-1:0] w_q;
    logic                    out_err_q;
    logic                    out_sat_q;
    logic                    out_valid_q;

    acc_t                    a_ext;
    logic                    a_nonpos;
    logic                    a_small;
    logic [CNT_W-1:0]        shift_s;
    acc_t                    atanh_t;
    logic signed [ACC_W:0]   z2r;
    logic signed [NUM_W-1:0] w_rnd;

    // 2.14 operand widened to the 4.18 internal format
    assign a_ext = {{(INT_W-2){io.a[NUM_W-1]}}, io.a, {GUARD_W{1'b0}}};
    assign a_nonpos = io.a[NUM_W-1] || (io.a == '0);
    assign a_small  = !a_nonpos && (io.a < NUM_W'(LN_A_MIN));

    assign shift_s = CNT_W'(SHIFT[cnt]);
    assign atanh_t = acc_t'(ATANH[cnt]);

    hyperbolic_vec_step u_step (
        .cur (vec_q),
        .s   (shift_s),
        .t   (atanh_t),
        .nxt (vec_nxt)
    );

    // 2*z back to 14 fraction bits, rounding half up
    assign z2r   = $signed({vec_q.z, 1'b0}) + RND_HALF;
    assign w_rnd = sat16(z2r[ACC_W:GUARD_W]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            vec_q       <= '0;
            err_q       <= 1'b0;
            sat_q       <= 1'b0;
            w_q         <= '0;
            out_err_q   <= 1'b0;
            out_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (io.in_valid) begin
                        vec_q.x <= a_ext + ONE;
                        vec_q.y <= a_ext - ONE;
                        vec_q.z <= '0;
                        err_q   <= a_nonpos;
                        sat_q   <= a_small;
                        cnt     <= '0;
                        state   <= S_ITER;
                    end
                end
                S_ITER: begin
                    vec_q <= vec_nxt;
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= S_FINAL;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_FINAL: begin
                    w_q         <= (err_q || sat_q) ? W_FLAG : w_rnd;
                    out_err_q   <= err_q;
                    out_sat_q   <= sat_q;
                    out_valid_q <= 1'b1;
                    state       <= S_DONE;
                end
                S_DONE: begin
                    if (io.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign io.in_ready  = (state == S_IDLE) && !rst;
    assign io.w         = w_q;
    assign io.out_err   = out_err_q;
    assign io.out_sat   = out_sat_q;
    assign io.out_valid = out_valid_q;

endmodule

// File: tb/tb_hyperbolic_ln_cordic.sv
// Bench for hyperbolic_ln_cordic: directed corner cases, mid-op reset
// and a random sweep compared with a real-valued ln() reference.
module tb_hyperbolic_ln_cordic;

    localparam int A_MIN  = 2218;
    localparam int W_FLAG = -32768;
    localparam int LAT    = 19;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    hyperbolic_ln_cordic_if bus ();

    hyperbolic_ln_cordic dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(
        input string tag,
        input int    got,
        input int    exp,
        input int    tol = 0
    );
        int d;
        n_chk++;
        d = got - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (tol %0d)",
                     tag, got, exp, tol);
        end
    endtask

    function automatic bit ref_err(input int av);
        return av <= 0;
    endfunction

    function automatic bit ref_sat(input int av);
        return av > 0 && av < A_MIN;
    endfunction

    function automatic int ref_w(input int av);
        real r;
        if (ref_err(av) || ref_sat(av)) return W_FLAG;
        r = $ln(av / 16384.0) * 16384.0;
        if (r < 0.0) return -$rtoi(-r + 0.5);
        return $rtoi(r + 0.5);
    endfunction

    task automatic do_op(
        input int    av,
        input int    stall,
        input bit    poke,
        input string tag
    );
        int cyc;
        int ew;
        int tol;
        cyc = 0;
        while (!bus.in_ready && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, " ready"}, int'(bus.in_ready), 1);
        bus.a        = 16'(av);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.a         = 16'($urandom);
        bus.out_ready = (stall == 0);
        cyc = 0;
        while (!bus.out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        ew  = ref_w(av);
        tol = (ref_err(av) || ref_sat(av)) ? 0 : 3;
        chk({tag, " latency"}, cyc, LAT);
        chk({tag, " w"}, int'(bus.w), ew, tol);
        chk({tag, " err"}, int'(bus.out_err), int'(ref_err(av)));
        chk({tag, " sat"}, int'(bus.out_sat), int'(ref_sat(av)));
        for (int i = 0; i < stall; i++) begin
            if (poke && i == 1) begin
                bus.a        = 16'sd8192;
                bus.in_valid = 1'b1;
            end
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            chk({tag, " hold valid"}, int'(bus.out_valid), 1);
            chk({tag, " hold w"}, int'(bus.w), ew, tol);
            if (poke)
                chk({tag, " hold busy"}, int'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({tag, " valid drop"}, int'(bus.out_valid), 0);
        chk({tag, " ready back"}, int'(bus.in_ready), 1);
    endtask

    initial begin
        int hits;
        int av;
        int r;
        bus.a         = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst ready", int'(bus.in_ready), 0);
        chk("rst valid", int'(bus.out_valid), 0);
        chk("rst w", int'(bus.w), 0);
        chk("rst err", int'(bus.out_err), 0);
        chk("rst sat", int'(bus.out_sat), 0);
        rst = 1'b0;
        #1;
        chk("rst release ready", int'(bus.in_ready), 1);

        do_op(16384, 0, 1'b0, "one");
        do_op(8192, 0, 1'b0, "half");
        do_op(24576, 1, 1'b0, "1.5");
        do_op(32767, 0, 1'b0, "max");
        do_op(A_MIN, 0, 1'b0, "amin");
        do_op(A_MIN - 1, 0, 1'b0, "amin-1");
        do_op(0, 0, 1'b0, "zero");
        do_op(-16384, 2, 1'b0, "neg");
        do_op(-32768, 0, 1'b0, "most neg");
        do_op(1000, 0, 1'b0, "small");

        // abandon an operand with reset while iterating at counter 9
        bus.a        = 16'sd24576;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst valid", int'(bus.out_valid), 0);
        chk("midrst w", int'(bus.w), 0);
        chk("midrst err", int'(bus.out_err), 0);
        chk("midrst sat", int'(bus.out_sat), 0);
        chk("midrst ready", int'(bus.in_ready), 0);
        rst = 1'b0;
        #1;
        chk("midrst ready back", int'(bus.in_ready), 1);
        hits = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) hits++;
        end
        chk("midrst no result", hits, 0);

        do_op(8192, 0, 1'b0, "post rst");
        do_op(16384, 5, 1'b1, "stall");
        do_op(24576, 0, 1'b0, "after stall");

        for (int n = 0; n < 2000; n++) begin
            av = int'($urandom_range(32767, A_MIN));
            r  = int'($urandom_range(7, 0));
            do_op(av, (r < 4) ? 0 : r - 3, 1'b0,
                  $sformatf("rnd a=%0d", av));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
